// File: rtl/seq_cmp.sv
// seq_cmp: digit-serial magnitude comparator, MSB digit first, with early exit on the first differing digit.
module seq_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  localparam int NDIG = WIDTH / DIGIT,
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1,
  localparam int DW = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic [DW-1:0]    digits
);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, sa, sb, smask;
  logic [DIGIT-1:0] da, db;
  logic [IW-1:0] idx;
  logic accept, last;
  assign accept = start && state != CMP;
  assign last = idx == IW'(NDIG - 1);
  assign sa = ra << (DIGIT * int'(idx));
  assign sb = rb << (DIGIT * int'(idx));
  assign da = sa[WIDTH-1 -: DIGIT];
  assign db = sb[WIDTH-1 -: DIGIT];
  // flipping the sign bit maps two's-complement order onto unsigned order
  assign smask = WIDTH'(signed_mode) << (WIDTH - 1);
  assign busy = state == CMP;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (accept) state_n = CMP;
    else if (state == DONE) state_n = IDLE;
    else if (state == CMP) state_n = (da != db || last) ? DONE : CMP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      idx <= '0;
      a_eq_b <= 1'b0;
      a_gt_b <= 1'b0;
      a_lt_b <= 1'b0;
      digits <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        ra <= a ^ smask;
        rb <= b ^ smask;
        idx <= '0;
        a_eq_b <= 1'b0;
        a_gt_b <= 1'b0;
        a_lt_b <= 1'b0;
        digits <= '0;
      end else if (state == CMP) begin
        if (da != db || last) begin
          a_gt_b <= da > db;
          a_lt_b <= da < db;
          a_eq_b <= da == db;
          digits <= DW'(idx) + DW'(1);
        end else idx <= idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_seq_cmp.sv
// tb_seq_cmp: directed scenario tests for seq_cmp at WIDTH=16, DIGIT=4.
module tb_seq_cmp;
  logic clk = 0, rst = 0, start = 0, signed_mode = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done, a_eq_b, a_gt_b, a_lt_b;
  logic [2:0] digits;
  int checks = 0, errors = 0;

  seq_cmp #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .digits(digits)
  );

  always #5 clk = ~clk;

  // outputs packed as {busy, done, eq, gt, lt, digits}
  function automatic logic [7:0] outs();
    return {busy, done, a_eq_b, a_gt_b, a_lt_b, digits};
  endfunction

  task automatic do_start(input logic [15:0] va, input logic [15:0] vb, input logic sm);
    @(negedge clk);
    a = va; b = vb; signed_mode = sm; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    checks++;
    if (outs() !== 8'b00_000_000) begin errors++; $display("FAIL reset outs got %b exp %b", outs(), 8'b00_000_000); end
  endtask

  task automatic test_equal;
    int n;
    do_start(16'h1234, 16'h1234, 0);
    checks++;
    if (outs() !== 8'b10_000_000) begin errors++; $display("FAIL equal_busy got %b exp %b", outs(), 8'b10_000_000); end
    wait_done(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL equal_latency got %0d exp 4", n); end
    checks++;
    if (outs() !== 8'b01_100_100) begin errors++; $display("FAIL equal_result got %b exp %b", outs(), 8'b01_100_100); end
    @(posedge clk); #1;
    checks++;
    if (outs() !== 8'b00_100_100) begin errors++; $display("FAIL equal_hold got %b exp %b", outs(), 8'b00_100_100); end
  endtask

  task automatic test_msb;
    int n;
    do_start(16'h8000, 16'h7FFF, 0);
    wait_done(n);
    checks++;
    if (n !== 1 || outs() !== 8'b01_010_001) begin errors++; $display("FAIL msb_unsigned got n=%0d %b exp n=1 %b", n, outs(), 8'b01_010_001); end
    do_start(16'h8000, 16'h7FFF, 1);
    wait_done(n);
    checks++;
    if (n !== 1 || outs() !== 8'b01_001_001) begin errors++; $display("FAIL msb_signed got n=%0d %b exp n=1 %b", n, outs(), 8'b01_001_001); end
  endtask

  task automatic test_mid;
    int n;
    do_start(16'h12A4, 16'h12B0, 0);
    wait_done(n);
    checks++;
    if (n !== 3 || outs() !== 8'b01_001_011) begin errors++; $display("FAIL mid_unsigned got n=%0d %b exp n=3 %b", n, outs(), 8'b01_001_011); end
    do_start(16'hFFFF, 16'h0001, 1);
    wait_done(n);
    checks++;
    if (n !== 1 || outs() !== 8'b01_001_001) begin errors++; $display("FAIL mid_signed got n=%0d %b exp n=1 %b", n, outs(), 8'b01_001_001); end
  endtask

  task automatic test_busy;
    int n, pulses;
    do_start(16'h0001, 16'h0000, 0);
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; signed_mode = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(n);
    checks++;
    if (n !== 3 || outs() !== 8'b01_010_100) begin errors++; $display("FAIL busy_ignore got n=%0d %b exp n=3 %b", n, outs(), 8'b01_010_100); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL busy_single_done got %0d extra pulses exp 0", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    do_start(16'h1234, 16'h1235, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (outs() !== 8'b00_000_000) begin errors++; $display("FAIL reset_mid got %b exp %b", outs(), 8'b00_000_000); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", pulses); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_start(16'h8000, 16'h0000, 0);
    wait_done(n);
    checks++;
    if (n !== 1 || outs() !== 8'b01_010_001) begin errors++; $display("FAIL b2b_first got n=%0d %b exp n=1 %b", n, outs(), 8'b01_010_001); end
    do_start(16'h0001, 16'h0002, 0);
    checks++;
    if (outs() !== 8'b10_000_000) begin errors++; $display("FAIL b2b_restart got %b exp %b", outs(), 8'b10_000_000); end
    wait_done(n);
    checks++;
    if (n !== 4 || outs() !== 8'b01_001_100) begin errors++; $display("FAIL b2b_second got n=%0d %b exp n=4 %b", n, outs(), 8'b01_001_100); end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_msb;
    test_mid;
    test_busy;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
